// File: rtl/floo_pkg.sv
// Shared types for the chimney route-table controller: config beat struct
// macro and the controller FSM encoding.
`ifndef FLOO_TYPEDEF_ROUTE_CFG_T
`define FLOO_TYPEDEF_ROUTE_CFG_T(cfg_t, idx_t, route_t) \
    typedef struct packed {                                \
        logic   commit;                                    \
        idx_t   idx;                                       \
        route_t route;                                     \
    } cfg_t;
`endif

package floo_pkg;

    typedef enum logic [1:0] {
        RtIdle,
        RtDrain,
        RtSwap
    } route_ctrl_state_e;

endpackage

// File: rtl/floo_inflight_cnt.sv
// Up/down saturating count of packets currently routed with the active table.
module floo_inflight_cnt #(
    parameter int unsigned MaxInflight = 15,
    parameter int unsigned CntWidth    = $clog2(MaxInflight + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxInflight);

    logic [CntWidth-1:0] cnt_q;

    // A start and an end in the same cycle cancel each other out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && !dec_i && (cnt_q != MaxCnt)) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    assign cnt_o = cnt_q;

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(inc_i && !dec_i && (cnt_q == MaxCnt)));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dec_i && !inc_i && (cnt_q == '0)));

endmodule

// File: rtl/floo_route_table_ctrl.sv
// Route-table configuration controller: collects entry writes in a shadow copy
// and, on commit, drains old-table packets before swapping shadow into active.
module floo_route_table_ctrl
    import floo_pkg::*;
#(
    parameter int unsigned NumRoutes   = 8,
    parameter type         route_t     = logic,
    parameter int unsigned MaxInflight = 15,
    parameter int unsigned IdxWidth    = (NumRoutes > 1) ? $clog2(NumRoutes) : 1,
    parameter int unsigned CntWidth    = $clog2(MaxInflight + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  cfg_valid_i,
    output logic                                  cfg_ready_o,
    input  logic                                  cfg_commit_i,
    input  logic [IdxWidth-1:0]                   cfg_idx_i,
    input  logic [$bits(route_t)-1:0]             cfg_route_i,
    input  logic                                  pkt_start_i,
    input  logic                                  pkt_end_i,
    output logic                                  stall_o,
    output logic [NumRoutes*$bits(route_t)-1:0]   route_table_o,
    output logic                                  table_valid_o,
    output logic                                  busy_o
);

    localparam int unsigned IdxWidthExt  = IdxWidth + 1;
    localparam logic [IdxWidth:0] NumRoutesIdx = IdxWidthExt'(NumRoutes);

    typedef logic [IdxWidth-1:0] idx_t;
    `FLOO_TYPEDEF_ROUTE_CFG_T(route_cfg_t, idx_t, route_t)

    route_ctrl_state_e       state_q, state_d;
    route_t [NumRoutes-1:0]  shadow_q, active_q;
    logic                    table_valid_q;
    logic [CntWidth-1:0]     inflight_cnt;
    route_cfg_t              cfg_beat;
    logic                    cfg_accept;
    logic                    idx_in_range;
    logic                    shadow_we;
    logic                    swap;

    assign cfg_beat     = '{commit: cfg_commit_i, idx: cfg_idx_i, route: cfg_route_i};
    assign cfg_accept   = cfg_valid_i && cfg_ready_o;
    assign idx_in_range = ({1'b0, cfg_beat.idx} < NumRoutesIdx);
    assign shadow_we    = cfg_accept && !cfg_beat.commit && idx_in_range;

    floo_inflight_cnt #(
        .MaxInflight (MaxInflight),
        .CntWidth    (CntWidth)
    ) i_inflight_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (pkt_start_i),
        .dec_i  (pkt_end_i),
        .cnt_o  (inflight_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RtIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain exits on the registered count, so a final pkt_end_i costs one extra cycle.
    always_comb begin
        state_d     = state_q;
        cfg_ready_o = 1'b0;
        swap        = 1'b0;
        unique case (state_q)
            RtIdle: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i && cfg_beat.commit) begin
                    state_d = RtDrain;
                end
            end
            RtDrain: begin
                if (inflight_cnt == '0) begin
                    state_d = RtSwap;
                end
            end
            RtSwap: begin
                swap    = 1'b1;
                state_d = RtIdle;
            end
            default: state_d = RtIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else if (shadow_we) begin
            shadow_q[cfg_beat.idx] <= cfg_beat.route;
        end
    end

    // The active table only ever moves here, keeping route_table_o stable otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q      <= '0;
            table_valid_q <= 1'b0;
        end else if (swap) begin
            active_q      <= shadow_q;
            table_valid_q <= 1'b1;
        end
    end

    assign route_table_o = active_q;
    assign table_valid_o = table_valid_q;
    assign busy_o        = (state_q != RtIdle);
    assign stall_o       = !table_valid_q || (state_q != RtIdle);

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pkt_start_i && stall_o));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(cfg_accept && !cfg_beat.commit && !idx_in_range));

endmodule

// File: tb/tb_floo_route_table_ctrl.sv
// Scoreboard bench for floo_route_table_ctrl: stimulus queues expected output
// snapshots per cycle, a negedge monitor pops and compares them.
module tb_floo_route_table_ctrl;

    localparam int unsigned NumRoutes = 8;
    localparam int unsigned RouteW    = 4;
    localparam int unsigned TableW    = NumRoutes * RouteW;

    localparam logic [TableW-1:0] T1 = 32'h00A0_0003;
    localparam logic [TableW-1:0] T2 = 32'h00A0_0007;
    localparam logic [TableW-1:0] T3 = 32'h00A0_0507;

    logic              clk;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_commit;
    logic [2:0]        cfg_idx;
    logic [RouteW-1:0] cfg_route;
    logic              pkt_start;
    logic              pkt_end;
    logic              stall;
    logic [TableW-1:0] route_table;
    logic              table_valid;
    logic              busy;

    int cyc           = 0;
    int checks        = 0;
    int errors        = 0;
    int table_changes = 0;

    string             exp_name[$];
    int                exp_cyc[$];
    logic [TableW+3:0] exp_vec[$];
    logic [TableW-1:0] prev_table = '0;

    floo_route_table_ctrl #(
        .NumRoutes   (NumRoutes),
        .route_t     (logic [RouteW-1:0]),
        .MaxInflight (15)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_commit_i  (cfg_commit),
        .cfg_idx_i     (cfg_idx),
        .cfg_route_i   (cfg_route),
        .pkt_start_i   (pkt_start),
        .pkt_end_i     (pkt_end),
        .stall_o       (stall),
        .route_table_o (route_table),
        .table_valid_o (table_valid),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [TableW+3:0] act,
                               input logic [TableW+3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @cyc %0d: got %h, expected %h (stall,ready,valid,busy|table)",
                     name, cyc, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every expectation whose cycle has arrived, and track table changes.
    always @(negedge clk) begin
        if (route_table !== prev_table) begin
            table_changes++;
            prev_table = route_table;
        end
        while (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
            string             n;
            int                c;
            logic [TableW+3:0] v;
            n = exp_name.pop_front();
            c = exp_cyc.pop_front();
            v = exp_vec.pop_front();
            if (c != cyc) begin
                checkCount({n, "_missed_cycle"}, cyc, c);
            end else begin
                checkOutput(n, {stall, cfg_ready, table_valid, busy, route_table}, v);
            end
        end
    end

    task automatic expectAt(input string name, input int offset, input logic e_stall,
                            input logic e_ready, input logic e_valid, input logic e_busy,
                            input logic [TableW-1:0] e_table);
        exp_name.push_back(name);
        exp_cyc.push_back(cyc + offset);
        exp_vec.push_back({e_stall, e_ready, e_valid, e_busy, e_table});
    endtask

    task automatic applyStimulus(input logic valid, input logic commit, input logic [2:0] idx,
                                 input logic [RouteW-1:0] route, input logic start,
                                 input logic fin);
        cfg_valid  = valid;
        cfg_commit = commit;
        cfg_idx    = idx;
        cfg_route  = route;
        pkt_start  = start;
        pkt_end    = fin;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        applyStimulus(0, 0, 3'd0, 4'h0, 0, 0);
        #1 rst_n = 1'b0;
        repeat (3) tick();
        expectAt("reset", 0, 1, 1, 0, 0, '0);
        tick();
        rst_n = 1'b1;
        tick();

        // First commit with no traffic.
        applyStimulus(1, 0, 3'd0, 4'h3, 0, 0); tick();
        applyStimulus(1, 0, 3'd5, 4'hA, 0, 0); tick();
        applyStimulus(1, 1, 3'd0, 4'h0, 0, 0); tick();
        applyStimulus(0, 0, 3'd0, 4'h0, 0, 0);
        expectAt("c1_drain", 0, 1, 0, 0, 1, '0);
        expectAt("c1_swap",  1, 1, 0, 0, 1, '0);
        expectAt("c1_new",   2, 0, 1, 1, 0, T1);
        tick(); tick();

        // Commit with three open packets and a write beat held through DRAIN.
        applyStimulus(0, 0, 3'd0, 4'h0, 1, 0); repeat (3) tick();
        applyStimulus(1, 0, 3'd0, 4'h7, 0, 0); tick();
        applyStimulus(1, 1, 3'd0, 4'h0, 0, 0); tick();
        applyStimulus(1, 0, 3'd2, 4'h5, 0, 0);
        for (int i = 0; i < 6; i++) begin
            expectAt($sformatf("c2_drain%0d", i), i, 1, 0, 1, 1, T1);
        end
        expectAt("c2_swap", 6, 1, 0, 1, 1, T1);
        expectAt("c2_new",  7, 0, 1, 1, 0, T2);
        tick(); tick();
        applyStimulus(1, 0, 3'd2, 4'h5, 0, 1); repeat (3) tick();
        applyStimulus(1, 0, 3'd2, 4'h5, 0, 0); repeat (3) tick();
        applyStimulus(0, 0, 3'd0, 4'h0, 0, 0);

        // Count to 2, hold simultaneous start/end, then commit and drain two packets.
        applyStimulus(0, 0, 3'd0, 4'h0, 1, 0); repeat (2) tick();
        applyStimulus(0, 0, 3'd0, 4'h0, 1, 1); repeat (4) tick();
        applyStimulus(1, 1, 3'd0, 4'h0, 0, 0); tick();
        applyStimulus(0, 0, 3'd0, 4'h0, 0, 1);
        expectAt("c3_drain0", 0, 1, 0, 1, 1, T2);
        expectAt("c3_drain1", 1, 1, 0, 1, 1, T2);
        expectAt("c3_drain2", 2, 1, 0, 1, 1, T2);
        expectAt("c3_swap",   3, 1, 0, 1, 1, T2);
        expectAt("c3_new",    4, 0, 1, 1, 0, T3);
        tick(); tick();
        applyStimulus(0, 0, 3'd0, 4'h0, 0, 0);
        tick(); tick();

        // Repeat commit without writes keeps the same table.
        applyStimulus(1, 1, 3'd0, 4'h0, 0, 0); tick();
        applyStimulus(0, 0, 3'd0, 4'h0, 0, 0);
        expectAt("c4_drain", 0, 1, 0, 1, 1, T3);
        expectAt("c4_swap",  1, 1, 0, 1, 1, T3);
        expectAt("c4_same",  2, 0, 1, 1, 0, T3);
        tick(); tick();

        // Asynchronous reset in the middle of DRAIN with two open packets.
        applyStimulus(0, 0, 3'd0, 4'h0, 1, 0); repeat (2) tick();
        applyStimulus(1, 1, 3'd0, 4'h0, 0, 0); tick();
        applyStimulus(0, 0, 3'd0, 4'h0, 0, 0);
        expectAt("r_drain", 0, 1, 0, 1, 1, T3);
        tick();
        #1 rst_n = 1'b0;
        expectAt("async_reset", 0, 1, 1, 0, 0, '0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        expectAt("post_reset", 0, 1, 1, 0, 0, '0);
        applyStimulus(1, 1, 3'd0, 4'h0, 0, 0); tick();
        applyStimulus(0, 0, 3'd0, 4'h0, 0, 0);
        expectAt("c5_drain", 0, 1, 0, 0, 1, '0);
        expectAt("c5_swap",  1, 1, 0, 0, 1, '0);
        expectAt("c5_new",   2, 0, 1, 1, 0, '0);
        repeat (3) tick();

        checkCount("table_changes", table_changes, 4);
        checkCount("pending_expectations", exp_cyc.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
